input_debouncer: RTL and testbench
==================================

# input_debouncer

Two-channel input conditioner that sits directly upstream of the two-input logic gates in the library. It turns raw, asynchronous, possibly bouncing signals (switches, off-board strobes) into clean, clock-synchronous levels A and B that can drive a gate's inputs directly. Each channel is synchronized and then debounced by a saturating stability counter. Each channel also produces a one-cycle change pulse.

## Interface

Parameters:
- SYNC_STAGES, default 2: synchronizer flops per channel. Legal range is 1 or more; 2 or more is required for truly asynchronous inputs.
- STABLE_CYCLES, default 4: number of consecutive cycles the synchronized value must differ from the current output before the output flips. Legal range is 1 or more.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- A_RAW  input  1  raw channel-A input, asynchronous to CLK.
- B_RAW  input  1  raw channel-B input, asynchronous to CLK.
- A  output  1  debounced, registered channel-A level.
- B  output  1  debounced, registered channel-B level.
- A_CHG  output  1  single-cycle pulse, high in the cycle A takes a new value.
- B_CHG  output  1  single-cycle pulse, high in the cycle B takes a new value.

## Operation

The two channels are identical and fully independent. No state is shared and there is no cross-channel interaction.

Per channel:
- Synchronizer: a shift chain of SYNC_STAGES flops. Its last stage is called `s`.
- Counter `cnt`: width clog2(STABLE_CYCLES+1). It never exceeds STABLE_CYCLES−1.
- Registers: output register `q` (drives A/B) and pulse register `chg` (drives A_CHG/B_CHG).

Per-edge rules, with `s` and `q` sampled before the edge:
- `s == q`: `cnt` ← 0, `chg` ← 0.
- `s != q` and `cnt < STABLE_CYCLES−1`: `cnt` ← `cnt`+1, `chg` ← 0.
- `s != q` and `cnt == STABLE_CYCLES−1`: `q` ← `s`, `cnt` ← 0, `chg` ← 1.

Consequences:
- A glitch shorter than STABLE_CYCLES cycles, as seen at `s`, clears the counter and never reaches the output.
- With STABLE_CYCLES = 1, the output follows `s` one edge later.
- `chg` is high for exactly one cycle per flip, in both directions.
- Back-to-back flips are impossible: after each flip the counter starts again from 0.

Reset:
- While RST is high, all synchronizer flops, `cnt`, `q` and `chg` are 0. This holds immediately, independent of CLK.
- Outputs A=0, B=0, A_CHG=0, B_CHG=0.
- If RST asserts mid-count, the count is discarded and no pulse is produced.
- After RST deasserts, a raw input held at 1 reaches the output with the full latency below.

## Timing

- Latency: a raw level change that is set up before edge 1 and held stable appears on the output at edge SYNC_STAGES + STABLE_CYCLES. With the defaults that is edge 6.
- `chg` asserts at the same edge as `q` and drops at the next edge.
- Minimum accepted pulse width: a raw pulse is guaranteed to be ignored if it spans fewer than STABLE_CYCLES edges. It is guaranteed to pass if it is held for at least STABLE_CYCLES edges (setup met).
- Simultaneous events:
  - Both channels may flip in the same cycle; both CHG outputs then pulse together.
  - If `s` returns to `q` in the same cycle the counter would have saturated, the flip does not happen. That cycle sees `s == q`, so the counter clears.
- Outputs are driven directly from flops, with no combinational path from any input. They are safe to feed combinational gates downstream.

## Structure

- Shared package or include holds:
  - the clog2 constant function, used for the counter width;
  - the default values of SYNC_STAGES and STABLE_CYCLES.
- No typedefs are needed.
- One sub-module, `debounce_channel`:
  - ports CLK, RST, RAW, Q, CHG;
  - parameters SYNC_STAGES and STABLE_CYCLES.
- input_debouncer instantiates `debounce_channel` twice, once for A and once for B. It adds no logic of its own.

## Test plan

All scenarios use the defaults (SYNC_STAGES=2, STABLE_CYCLES=4) unless stated otherwise.

- **Reset values:** with RST=1, A_RAW=1, B_RAW=1, check A=B=A_CHG=B_CHG=0 before any CLK edge. Release RST and hold the inputs → A and B rise at edge 6, with A_CHG and B_CHG high for that one cycle only.
- **Glitch rejection:** A_RAW pulses high for 3 cycles, then low → A stays 0 and A_CHG never asserts. Repeat with a 4-cycle pulse → A goes to 1 at edge 6 and returns to 0 exactly 4 cycles later.
- **Bounce then settle:** A_RAW toggles 1,0,1,0,1 on successive cycles, then holds 1 → A rises exactly 6 edges after the final 0→1 transition, with a single A_CHG pulse.
- **Channel independence:** drive B_RAW with 2-cycle glitches while A_RAW steps to 1 → A and A_CHG behave as in the solo case, and B stays 0. Then step both inputs on the same edge → both CHG outputs pulse in the same cycle.
- **Reset mid-count:** step A_RAW to 1, assert RST at edge 4 for 1 cycle, then release → A stays 0 until 6 edges after the release, and no pulse occurs before that.
- **Parameter corner:** with STABLE_CYCLES=1 and SYNC_STAGES=1, A follows A_RAW with 2 edges of latency, and A_CHG pulses on every toggle, including a toggle on every cycle.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared constants and helpers for the two-channel input debouncer.
package input_debouncer_pkg;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;

  // Bits needed to hold values 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchronizer chain feeding a saturating stability counter.
module debounce_channel
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic Q,
  output logic CHG
);

  localparam int CW = clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Written stage by stage so a single-stage chain needs no special case.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= RAW;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
      Q   <= 1'b0;
      CHG <= 1'b0;
    end else if (s == Q) begin
      cnt <= '0;
      CHG <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      Q   <= s;
      cnt <= '0;
      CHG <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      CHG <= 1'b0;
    end
  end

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce lanes producing clean A/B levels and change pulses.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic CLK,
  input  logic RST,
  input  logic A_RAW,
  input  logic B_RAW,
  output logic A,
  output logic B,
  output logic A_CHG,
  output logic B_CHG
);

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_ch_a (
    .CLK(CLK), .RST(RST), .RAW(A_RAW), .Q(A), .CHG(A_CHG)
  );

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_ch_b (
    .CLK(CLK), .RST(RST), .RAW(B_RAW), .Q(B), .CHG(B_CHG)
  );

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench: window-based reference model checked every cycle, plus literal expectations.
module tb_input_debouncer;

  logic CLK = 1'b0;
  logic RST;
  logic A_RAW, B_RAW, c_raw, d_raw;
  logic A, B, A_CHG, B_CHG;
  logic c_q, d_q, c_chg, d_chg;

  int total = 0;
  int bad   = 0;
  bit run   = 0;

  always #5 CLK = ~CLK;

  input_debouncer dut (
    .CLK(CLK), .RST(RST), .A_RAW(A_RAW), .B_RAW(B_RAW),
    .A(A), .B(B), .A_CHG(A_CHG), .B_CHG(B_CHG)
  );

  input_debouncer #(.SYNC_STAGES(1), .STABLE_CYCLES(1)) dut_c (
    .CLK(CLK), .RST(RST), .A_RAW(c_raw), .B_RAW(d_raw),
    .A(c_q), .B(d_q), .A_CHG(c_chg), .B_CHG(d_chg)
  );

  // Reference model: output flips at edge n when s (raw delayed SYNC edges) has
  // differed from the output on every one of the last STABLE edges since the last flip/reset.
  logic hist [4][2048];
  int   lastf [4];
  logic mq [4];
  logic mc [4];
  int   n = 0;

  initial begin
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2048; k++) hist[c][k] = 1'b0;
      lastf[c] = 0; mq[c] = 1'b0; mc[c] = 1'b0;
    end
  end

  function automatic logic s_at(int ch, int j, int ss);
    return (j - ss < 0) ? 1'b0 : hist[ch][j-ss];
  endfunction

  function automatic void step(int ch, logic raw, int ss, int st);
    logic fl;
    if (RST) begin
      for (int k = n - ss + 1; k <= n; k++) if (k >= 0) hist[ch][k] = 1'b0;
      lastf[ch] = n; mq[ch] = 1'b0; mc[ch] = 1'b0;
    end else begin
      hist[ch][n] = raw;
      fl = 1'b1;
      for (int j = n - st + 1; j <= n; j++)
        if (j <= lastf[ch] || s_at(ch, j, ss) == mq[ch]) fl = 1'b0;
      mc[ch] = fl;
      if (fl) begin mq[ch] = ~mq[ch]; lastf[ch] = n; end
    end
  endfunction

  always @(posedge CLK) begin
    n++;
    step(0, A_RAW, 2, 4);
    step(1, B_RAW, 2, 4);
    step(2, c_raw, 1, 1);
    step(3, d_raw, 1, 1);
  end

  task automatic chk(string nm, logic got, logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (run) begin
      chk("mdl_a",     A,     RST ? 1'b0 : mq[0]);
      chk("mdl_a_chg", A_CHG, RST ? 1'b0 : mc[0]);
      chk("mdl_b",     B,     RST ? 1'b0 : mq[1]);
      chk("mdl_b_chg", B_CHG, RST ? 1'b0 : mc[1]);
      chk("mdl_c",     c_q,   RST ? 1'b0 : mq[2]);
      chk("mdl_c_chg", c_chg, RST ? 1'b0 : mc[2]);
      chk("mdl_d",     d_q,   RST ? 1'b0 : mq[3]);
      chk("mdl_d_chg", d_chg, RST ? 1'b0 : mc[3]);
    end
  end

  task automatic tick(int k);
    repeat (k) @(posedge CLK);
    #2;
  endtask

  logic [10:0] exp_cq  = 11'b11001010110; // bit e-1 = expected c_q after edge e
  logic [10:0] exp_cch = 11'b01011111010;

  initial begin
    RST = 1'b1; A_RAW = 1'b1; B_RAW = 1'b1; c_raw = 1'b0; d_raw = 1'b0;
    #1;
    chk("rst_a", A, 1'b0); chk("rst_b", B, 1'b0);
    chk("rst_a_chg", A_CHG, 1'b0); chk("rst_b_chg", B_CHG, 1'b0);
    #1 RST = 1'b0;
    run = 1;

    // Release with inputs high: rise at edge 6
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("rel_a", A, e >= 6); chk("rel_a_chg", A_CHG, e == 6);
      chk("rel_b", B, e >= 6); chk("rel_b_chg", B_CHG, e == 6);
    end
    A_RAW = 0; B_RAW = 0; tick(10);

    // 3-cycle glitch rejected
    A_RAW = 1; tick(3); A_RAW = 0;
    for (int e = 4; e <= 12; e++) begin
      tick(1);
      chk("gl3_a", A, 1'b0); chk("gl3_a_chg", A_CHG, 1'b0);
    end

    // 4-cycle pulse passes: up at edge 6, down at edge 10
    for (int e = 1; e <= 12; e++) begin
      A_RAW = (e <= 4);
      tick(1);
      chk("gl4_a", A, e >= 6 && e < 10);
      chk("gl4_a_chg", A_CHG, e == 6 || e == 10);
    end
    tick(5);

    // Bounce 1,0,1,0,1 then hold: single rise at edge 10
    for (int e = 1; e <= 13; e++) begin
      A_RAW = (e >= 5) ? 1'b1 : ((e % 2) == 1);
      tick(1);
      chk("bnc_a", A, e >= 10); chk("bnc_a_chg", A_CHG, e == 10);
    end
    A_RAW = 0; tick(10);

    // A steps while B glitches in 2-cycle runs
    for (int e = 1; e <= 12; e++) begin
      A_RAW = 1; B_RAW = (((e - 1) / 2) % 2) == 0;
      tick(1);
      chk("ind_a", A, e >= 6); chk("ind_a_chg", A_CHG, e == 6);
      chk("ind_b", B, 1'b0); chk("ind_b_chg", B_CHG, 1'b0);
    end
    B_RAW = 0; tick(10);

    // Both flip in the same cycle
    A_RAW = 0; B_RAW = 1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("sim_a", A, e < 6); chk("sim_b", B, e >= 6);
      chk("sim_a_chg", A_CHG, e == 6); chk("sim_b_chg", B_CHG, e == 6);
    end
    B_RAW = 0; tick(10);

    // Reset asserted during a count discards it
    A_RAW = 1; tick(3);
    RST = 1; #1;
    chk("mid_rst_a", A, 1'b0); chk("mid_rst_a_chg", A_CHG, 1'b0);
    tick(1);
    RST = 0;
    for (int r = 1; r <= 8; r++) begin
      tick(1);
      chk("mid_a", A, r >= 6); chk("mid_a_chg", A_CHG, r == 6);
    end

    // Corner instance: one sync stage, one stable cycle
    for (int e = 1; e <= 11; e++) begin
      case (e)
        1, 2, 4, 6, 9, 10, 11: c_raw = 1'b1;
        default:               c_raw = 1'b0;
      endcase
      tick(1);
      chk("cor_q", c_q, exp_cq[e-1]); chk("cor_chg", c_chg, exp_cch[e-1]);
    end
    tick(3);

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
